// File: rtl/wr_stream_serializer.sv
// Write-side feeder for the dual-clock FIFO: serializes multi-lane words into
// single-lane FIFO writes under the FIFO full flag and reports per-frame lengths.
module wr_stream_serializer #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4,
  parameter int CNTW  = $clog2(RATIO) + 1,
  parameter int LENW  = 16
) (
  input  logic                   wclk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*RATIO-1:0] in_data,
  input  logic [CNTW-1:0]        in_cnt,
  input  logic                   in_last,
  output logic                   fifo_wen,
  output logic [WIDTH-1:0]       fifo_data,
  input  logic                   fifo_full,
  output logic                   frame_done,
  output logic [LENW-1:0]        frame_len,
  output logic                   frame_ovf
);

  localparam int IDXW = $clog2(RATIO);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH*RATIO-1:0] hold_data_q, hold_data_d;
  logic [CNTW-1:0]        hold_cnt_q, hold_cnt_d;
  logic                   hold_last_q, hold_last_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic [LENW-1:0]        len_cnt_q, len_cnt_d;
  logic                   sat_q, sat_d;
  logic                   frame_done_q, frame_done_d;
  logic [LENW-1:0]        frame_len_q, frame_len_d;
  logic                   frame_ovf_q, frame_ovf_d;

  logic                   last_lane;
  logic                   wr_en;
  logic                   accept;
  logic                   len_at_max;
  logic [LENW-1:0]        len_inc;

  // Out-of-range lane counts (0 or above RATIO) mean a full word.
  function automatic logic [CNTW-1:0] sanitize_cnt(input logic [CNTW-1:0] c);
    if (c == '0 || int'(c) > RATIO) return CNTW'(RATIO);
    return c;
  endfunction

  assign last_lane  = (CNTW'(idx_q) == hold_cnt_q - CNTW'(1));
  assign wr_en      = (state_q == SEND) && !fifo_full;
  assign in_ready   = (state_q == IDLE) || (wr_en && last_lane);
  assign accept     = in_valid && in_ready;
  assign fifo_wen   = wr_en;
  assign fifo_data  = (state_q == SEND) ? hold_data_q[idx_q*WIDTH +: WIDTH] : '0;
  assign len_at_max = &len_cnt_q;
  assign len_inc    = len_at_max ? len_cnt_q : len_cnt_q + LENW'(1);

  assign frame_done = frame_done_q;
  assign frame_len  = frame_len_q;
  assign frame_ovf  = frame_ovf_q;

  always_comb begin
    state_d      = state_q;
    hold_data_d  = hold_data_q;
    hold_cnt_d   = hold_cnt_q;
    hold_last_d  = hold_last_q;
    idx_d        = idx_q;
    len_cnt_d    = len_cnt_q;
    sat_d        = sat_q;
    frame_done_d = 1'b0;
    frame_len_d  = frame_len_q;
    frame_ovf_d  = frame_ovf_q;

    if (wr_en) begin
      len_cnt_d = len_inc;
      sat_d     = sat_q | len_at_max;
      if (last_lane) begin
        state_d = IDLE;
        idx_d   = '0;
        // Closing a frame publishes the count and restarts it from zero.
        if (hold_last_q) begin
          frame_done_d = 1'b1;
          frame_len_d  = len_inc;
          frame_ovf_d  = sat_q | len_at_max;
          len_cnt_d    = '0;
          sat_d        = 1'b0;
        end
      end else begin
        idx_d = idx_q + IDXW'(1);
      end
    end

    if (accept) begin
      state_d     = SEND;
      hold_data_d = in_data;
      hold_cnt_d  = sanitize_cnt(in_cnt);
      hold_last_d = in_last;
      idx_d       = '0;
    end
  end

  always_ff @(posedge wclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hold_data_q  <= '0;
      hold_cnt_q   <= '0;
      hold_last_q  <= 1'b0;
      idx_q        <= '0;
      len_cnt_q    <= '0;
      sat_q        <= 1'b0;
      frame_done_q <= 1'b0;
      frame_len_q  <= '0;
      frame_ovf_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      hold_cnt_q   <= hold_cnt_d;
      hold_last_q  <= hold_last_d;
      idx_q        <= idx_d;
      len_cnt_q    <= len_cnt_d;
      sat_q        <= sat_d;
      frame_done_q <= frame_done_d;
      frame_len_q  <= frame_len_d;
      frame_ovf_q  <= frame_ovf_d;
    end
  end

endmodule
